mips32_mem_arbiter: RTL
=======================

# mips32_mem_arbiter

Single-port memory arbiter for the MIPS32 pipelined core. The core's instruction fetch (IF) and data access (MEM stage) share one 1024×32 memory with a debug/loader port. This block grants one requester per transaction and sequences the memory's read latency. It also returns read data to the granted requester and guarantees that instruction fetch cannot be starved by data traffic.

## Interface
- `ADDR_W`, 10, memory word-address width
- `DATA_W`, 32, data width
- `MEM_LAT`, 1, memory read latency in cycles (legal 1..4)
- `STARVE_MAX`, 4, consecutive denied IF cycles before IF is forced to win
- `clk1`  in  1  single clock, all logic on rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `hold`  in  1  freeze new IF/DM grants (core halted); the DBG port is still served
- `if_req`, `if_addr`  in  1/ADDR_W  fetch request, read only
- `if_gnt`, `if_rvalid`  out  1/1  grant; read data valid
- `if_rdata`  out  DATA_W  fetch data
- `dm_req`, `dm_we`, `dm_addr`, `dm_wdata`  in  1/1/ADDR_W/DATA_W  data port (LW/SW)
- `dm_gnt`, `dm_rvalid`  out  1/1
- `dm_rdata`  out  DATA_W
- `dbg_req`, `dbg_we`, `dbg_addr`, `dbg_wdata`  in  1/1/ADDR_W/DATA_W  debug/loader port
- `dbg_gnt`, `dbg_rvalid`  out  1/1
- `dbg_rdata`  out  DATA_W
- `mem_en`, `mem_we`  out  1/1  memory strobe and write enable
- `mem_addr`, `mem_wdata`  out  ADDR_W/DATA_W
- `mem_rdata`  in  DATA_W  valid `MEM_LAT` cycles after a read strobe
- `busy`  out  1  read outstanding

## Operation
- FSM states: IDLE and RD_WAIT.
- **IDLE:** if any eligible request is present, pick a winner and assert its `gnt` for one cycle. In the same cycle drive `mem_en=1`, with `mem_we`, `mem_addr` and `mem_wdata` taken combinationally from the winner.
- **Priority:** DBG > DM > IF. The exception is when `starve_cnt == STARVE_MAX` and `if_req` is high: then IF beats DM, but never DBG.
- **Writes** (`we=1`) complete in the grant cycle. There is no `rvalid`, and the FSM stays in IDLE.
- **Reads** load `lat_cnt = MEM_LAT`, latch the owner port, and move to RD_WAIT.
- **RD_WAIT:** decrement `lat_cnt` each cycle. No grants are issued while `lat_cnt > 1` after the decrement.
- **Read completion:** on the cycle `mem_rdata` is valid (`MEM_LAT` cycles after the grant), assert `<owner>_rvalid` for one cycle. `<owner>_rdata = mem_rdata`; the other ports' `rdata` is held at 0. Arbitration as in IDLE may occur in this same cycle, so back-to-back reads are allowed.
- **Requester rule:** hold `req`, `we`, `addr` and `wdata` stable until `gnt`. Dropping `req` before `gnt` withdraws the request with no side effect.
- **hold=1:** IF and DM are ineligible and DBG is still arbitrated. An outstanding read always completes.
- **starve_cnt** (3 bits, saturating at `STARVE_MAX`):
  - increments each cycle `if_req` is high, IF is eligible and `if_gnt=0`;
  - clears on `if_gnt` or when `if_req` is low;
  - holds its value while `hold=1`.
- **Unused strobes:** `mem_en=0` when nothing is granted; `mem_we` is forced to 0 whenever `mem_en=0`.

## Timing
- **Reset values:** all `gnt`, `rvalid`, `mem_en`, `mem_we` and `busy` are 0; all `rdata`, `mem_addr` and `mem_wdata` are 0; FSM in IDLE; `starve_cnt = 0`; `lat_cnt = 0`.
- **Grant to data:** a grant at cycle T gives `rvalid` at T+`MEM_LAT`.
- **Read throughput:** one read per `MEM_LAT` cycles. With `MEM_LAT=1`, one read per cycle.
- **Write throughput:** one write per cycle.
- **busy:** high from T+1 through T+`MEM_LAT`-1. It is low when `MEM_LAT=1`, except that `busy` is still registered.
- **Reset mid-read:** the outstanding read is dropped and no `rvalid` is issued after reset is released.
- **Simultaneous requests in one cycle:** exactly one `gnt` is asserted.
- **Read address collision:** a DM write and a DBG read to the same address in consecutive cycles return the post-write value (memory ordering is grant order).

## Structure
- Shared package `mips32_pkg`:
  - port enum `PORT_NONE`, `PORT_IF`, `PORT_DM`, `PORT_DBG`;
  - FSM state enum;
  - memory depth/width constants, alongside the existing opcode and instruction-type constants.
- One sub-module `mips32_arb_pick`: purely combinational. Inputs are the eligible request vector and the starvation flag; output is the one-hot winner.
- The top level holds the FSM, `lat_cnt`, `starve_cnt`, owner register and the response mux.

## Test plan
- **Reset:** with `rst_n` asserted, all outputs are 0. Release reset, then `if_req=1`, `if_addr=5` → `if_gnt` in the next cycle, `mem_addr=5`. With memory word 5 = `0x2821000A` and `MEM_LAT=1`, `if_rvalid=1` and `if_rdata=0x2821000A` one cycle later.
- **Three-way contest:** DBG, DM and IF all request in the same cycle → grant order DBG, DM, IF on successive grant slots. `MEM_LAT=2` reads return `rvalid` exactly 2 cycles after each grant.
- **Starvation:** `dm_req` held high continuously and `if_req` held high, `STARVE_MAX=4` → `if_gnt` no later than the 5th IF-eligible cycle. `starve_cnt` then returns to 0.
- **Hold:** `hold=1` with `dm_req` and `dbg_req` high (DBG write `0xDEADBEEF` to address 10) → only `dbg_gnt` is asserted and memory address 10 is written. `dm_gnt` stays 0 until `hold=0`.
- **Reset mid-read:** assert `rst_n=0` during RD_WAIT with `MEM_LAT=3` → no `rvalid` ever appears for that read, and the FSM is IDLE after release.
- **Write then read:** DM write `0x0000002A` to address 7, then DBG read of address 7 on the next slot → `dbg_rdata=0x0000002A`.

Source files
------------

// File: rtl/mips32_pkg.sv
// Shared MIPS32 core definitions: memory geometry, opcodes, instruction
// classes and the memory-arbiter port/state encodings.
package mips32_pkg;

  localparam int MEM_DEPTH = 1024;
  localparam int MEM_AW    = $clog2(MEM_DEPTH);
  localparam int MEM_DW    = 32;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  typedef enum logic [1:0] {
    ITYPE_R   = 2'd0,
    ITYPE_I   = 2'd1,
    ITYPE_J   = 2'd2,
    ITYPE_BAD = 2'd3
  } instr_type_e;

  typedef enum logic [1:0] {
    PORT_NONE = 2'd0,
    PORT_IF   = 2'd1,
    PORT_DM   = 2'd2,
    PORT_DBG  = 2'd3
  } port_e;

  typedef enum logic {
    IDLE    = 1'b0,
    RD_WAIT = 1'b1
  } arb_state_e;

  // Bit positions inside the request/grant vectors.
  localparam int WIN_IF  = 0;
  localparam int WIN_DM  = 1;
  localparam int WIN_DBG = 2;

  function automatic instr_type_e instr_type(input logic [5:0] opcode);
    instr_type_e t;
    case (opcode)
      OP_RTYPE:                   t = ITYPE_R;
      OP_J:                       t = ITYPE_J;
      OP_BEQ, OP_ADDI, OP_LW,
      OP_SW:                      t = ITYPE_I;
      default:                    t = ITYPE_BAD;
    endcase
    return t;
  endfunction

endpackage

// File: rtl/mips32_arb_pick.sv
// Combinational winner selection for the memory arbiter: DBG > DM > IF,
// except a starved IF request overtakes DM (never DBG).
module mips32_arb_pick
  import mips32_pkg::*;
(
  input  logic [2:0] elig,
  input  logic       starve,
  output logic [2:0] win
);

  // One-hot winner from the eligible vector.
  always_comb begin
    win = 3'b000;
    if (elig[WIN_DBG]) begin
      win[WIN_DBG] = 1'b1;
    end else if (elig[WIN_IF] && starve) begin
      win[WIN_IF] = 1'b1;
    end else if (elig[WIN_DM]) begin
      win[WIN_DM] = 1'b1;
    end else if (elig[WIN_IF]) begin
      win[WIN_IF] = 1'b1;
    end else begin
      win = 3'b000;
    end
  end

endmodule

// File: rtl/mips32_mem_arbiter.sv
// Single-port memory arbiter shared by instruction fetch, data access and the
// debug/loader port; sequences the memory read latency and routes read data.
module mips32_mem_arbiter
  import mips32_pkg::*;
#(
  parameter int ADDR_W     = MEM_AW,
  parameter int DATA_W     = MEM_DW,
  parameter int MEM_LAT    = 1,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk1,
  input  logic              rst_n,
  input  logic              hold,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic              dm_gnt,
  output logic              dm_rvalid,
  output logic [DATA_W-1:0] dm_rdata,
  input  logic              dbg_req,
  input  logic              dbg_we,
  input  logic [ADDR_W-1:0] dbg_addr,
  input  logic [DATA_W-1:0] dbg_wdata,
  output logic              dbg_gnt,
  output logic              dbg_rvalid,
  output logic [DATA_W-1:0] dbg_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  localparam logic [2:0] LAT_INIT   = 3'(MEM_LAT);
  localparam logic [2:0] STARVE_LIM = 3'(STARVE_MAX);

  arb_state_e state_r, state_nxt_s;
  logic [2:0] lat_cnt_r, lat_cnt_nxt_s;
  logic [2:0] starve_cnt_r, starve_cnt_nxt_s;
  port_e      owner_r, owner_nxt_s;
  port_e      gnt_port_s;
  logic       busy_nxt_s;
  logic       done_s, open_s, starve_s, rd_gnt_s;
  logic [2:0] elig_s, win_s, gnt_s;

  // Eligibility: a halted core keeps only the debug port arbitrable.
  always_comb begin
    elig_s   = {dbg_req, dm_req & ~hold, if_req & ~hold};
    starve_s = (starve_cnt_r == STARVE_LIM) && if_req;
  end

  mips32_arb_pick u_pick (
    .elig   (elig_s),
    .starve (starve_s),
    .win    (win_s)
  );

  // Grants are only issued in IDLE or in the cycle the pending read returns.
  always_comb begin
    done_s = (state_r == RD_WAIT) && (lat_cnt_r == 3'd1);
    open_s = (state_r == IDLE) || done_s;
    gnt_s  = open_s ? win_s : 3'b000;
  end

  // Grant outputs and memory strobe taken from the winning port.
  always_comb begin
    if_gnt     = gnt_s[WIN_IF];
    dm_gnt     = gnt_s[WIN_DM];
    dbg_gnt    = gnt_s[WIN_DBG];
    mem_en     = |gnt_s;
    mem_we     = 1'b0;
    mem_addr   = {ADDR_W{1'b0}};
    mem_wdata  = {DATA_W{1'b0}};
    gnt_port_s = PORT_NONE;
    case (gnt_s)
      3'b001: begin
        mem_addr   = if_addr;
        gnt_port_s = PORT_IF;
      end
      3'b010: begin
        mem_we     = dm_we;
        mem_addr   = dm_addr;
        mem_wdata  = dm_wdata;
        gnt_port_s = PORT_DM;
      end
      3'b100: begin
        mem_we     = dbg_we;
        mem_addr   = dbg_addr;
        mem_wdata  = dbg_wdata;
        gnt_port_s = PORT_DBG;
      end
      default: begin
        mem_we     = 1'b0;
        gnt_port_s = PORT_NONE;
      end
    endcase
    rd_gnt_s = mem_en && !mem_we;
  end

  // FSM next state, latency countdown and read owner.
  always_comb begin
    state_nxt_s   = state_r;
    lat_cnt_nxt_s = lat_cnt_r;
    owner_nxt_s   = owner_r;
    if (open_s) begin
      if (rd_gnt_s) begin
        state_nxt_s   = RD_WAIT;
        lat_cnt_nxt_s = LAT_INIT;
        owner_nxt_s   = gnt_port_s;
      end else begin
        state_nxt_s   = IDLE;
        lat_cnt_nxt_s = 3'd0;
        owner_nxt_s   = PORT_NONE;
      end
    end else begin
      state_nxt_s   = RD_WAIT;
      lat_cnt_nxt_s = lat_cnt_r - 3'd1;
      owner_nxt_s   = owner_r;
    end
    busy_nxt_s = (state_nxt_s == RD_WAIT) && (lat_cnt_nxt_s > 3'd1);
  end

  // Starvation counter: frozen while halted, saturates at the limit.
  always_comb begin
    if (hold) begin
      starve_cnt_nxt_s = starve_cnt_r;
    end else if (!if_req || gnt_s[WIN_IF]) begin
      starve_cnt_nxt_s = 3'd0;
    end else if (starve_cnt_r >= STARVE_LIM) begin
      starve_cnt_nxt_s = STARVE_LIM;
    end else begin
      starve_cnt_nxt_s = starve_cnt_r + 3'd1;
    end
  end

  // Read response routed to the owner only; other ports see zero data.
  always_comb begin
    if_rvalid  = done_s && (owner_r == PORT_IF);
    dm_rvalid  = done_s && (owner_r == PORT_DM);
    dbg_rvalid = done_s && (owner_r == PORT_DBG);
    if_rdata   = if_rvalid  ? mem_rdata : {DATA_W{1'b0}};
    dm_rdata   = dm_rvalid  ? mem_rdata : {DATA_W{1'b0}};
    dbg_rdata  = dbg_rvalid ? mem_rdata : {DATA_W{1'b0}};
  end

  // State registers; a reset drops any outstanding read.
  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= IDLE;
      lat_cnt_r    <= 3'd0;
      starve_cnt_r <= 3'd0;
      owner_r      <= PORT_NONE;
      busy         <= 1'b0;
    end else begin
      state_r      <= state_nxt_s;
      lat_cnt_r    <= lat_cnt_nxt_s;
      starve_cnt_r <= starve_cnt_nxt_s;
      owner_r      <= owner_nxt_s;
      busy         <= busy_nxt_s;
    end
  end

endmodule
